// File: rtl/pong_pkg.sv
// Shared game constants, state encoding and small helpers for the pong engine
// and the VGA renderer.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int PADDLE_HALF = 20;
  localparam int BALL_HALF   = 5;
  localparam int P1_X        = 10;
  localparam int P2_X        = 629;
  localparam int PADDLE_STEP = 4;
  localparam int BALL_STEP   = 2;
  localparam int SCORE_MAX   = 9;
  localparam int HOLD_FRAMES = 60;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= 4'(SCORE_MAX)) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_position_engine_if.sv
// Player inputs and renderer-facing coordinates of the pong engine.
// Handshake: none; frame_tick is a one-cycle strobe and every output is a
// registered level that only changes on the cycle after a frame_tick.
interface pong_position_engine_if;
  logic       frame_tick;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic       serve;
  logic [9:0] position_x_p1;
  logic [9:0] position_y_p1;
  logic [9:0] position_x_p2;
  logic [9:0] position_y_p2;
  logic [9:0] position_ball_x;
  logic [9:0] position_ball_y;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [1:0] game_state;
  logic       game_over;
  logic       dbg_dir_x;
  logic       dbg_dir_y;

  modport slave (
    input  frame_tick, p1_up, p1_down, p2_up, p2_down, serve,
    output position_x_p1, position_y_p1, position_x_p2, position_y_p2,
           position_ball_x, position_ball_y, score_p1, score_p2,
           game_state, game_over, dbg_dir_x, dbg_dir_y
  );

  modport master (
    output frame_tick, p1_up, p1_down, p2_up, p2_down, serve,
    input  position_x_p1, position_y_p1, position_x_p2, position_y_p2,
           position_ball_x, position_ball_y, score_p1, score_p2,
           game_state, game_over, dbg_dir_x, dbg_dir_y
  );
endinterface

// File: rtl/pong_paddle_ctrl.sv
// One paddle: turns level buttons into a clamped centre y, one step per frame.
module pong_paddle_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_hold,
  input  logic       i_restart,
  input  logic       i_up,
  input  logic       i_down,
  output logic [9:0] o_y
);

  localparam logic signed [10:0] C_MIN  = 11'(PADDLE_HALF);
  localparam logic signed [10:0] C_MAX  = 11'(V_ACTIVE - 1 - PADDLE_HALF);
  localparam logic signed [10:0] C_STEP = 11'(PADDLE_STEP);
  localparam logic [9:0]         C_HOME = 10'(V_ACTIVE / 2);

  logic [9:0]         r_y;
  logic signed [10:0] w_cur;
  logic signed [10:0] w_next;

  always_comb begin
    w_cur  = $signed({1'b0, r_y});
    w_next = w_cur;
    if (i_up && !i_down)      w_next = w_cur - C_STEP;
    else if (i_down && !i_up) w_next = w_cur + C_STEP;
    if (w_next < C_MIN)       w_next = C_MIN;
    else if (w_next > C_MAX)  w_next = C_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= C_HOME;
    end else if (i_tick) begin
      if (i_restart)    r_y <= C_HOME;
      else if (!i_hold) r_y <= w_next[10] ? 10'd0 : w_next[9:0];
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/pong_position_engine.sv
// Pong game-state engine: paddles, ball motion/collisions, scoring and the
// serve/play/point/over sequence, all advancing once per frame_tick.
module pong_position_engine
  import pong_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  pong_position_engine_if.slave  bus
);

  localparam logic signed [10:0] C_BSTEP = 11'(BALL_STEP);
  localparam logic signed [10:0] C_BHALF = 11'(BALL_HALF);
  localparam logic signed [10:0] C_REACH = 11'(PADDLE_HALF + BALL_HALF);
  localparam logic signed [10:0] C_P1_X  = 11'(P1_X);
  localparam logic signed [10:0] C_P2_X  = 11'(P2_X);
  localparam logic signed [10:0] C_Y_HI  = 11'(V_ACTIVE - 1 - BALL_HALF);
  localparam logic signed [10:0] C_X_HI  = 11'(H_ACTIVE - 1 - BALL_HALF);
  localparam logic signed [10:0] C_HIT1  = 11'(P1_X + 1 + BALL_HALF);
  localparam logic signed [10:0] C_HIT2  = 11'(P2_X - 1 - BALL_HALF);
  localparam logic [9:0]         C_CX    = 10'(H_ACTIVE / 2);
  localparam logic [9:0]         C_CY    = 10'(V_ACTIVE / 2);
  localparam logic [5:0]         C_HOLD_LAST = 6'(HOLD_FRAMES - 1);

  game_state_t r_state;
  logic [9:0]  r_ball_x;
  logic [9:0]  r_ball_y;
  logic [3:0]  r_score_p1;
  logic [3:0]  r_score_p2;
  logic        r_dir_x;   // 1 = moving right
  logic        r_dir_y;   // 1 = moving down
  logic [5:0]  r_hold;

  logic [9:0]         w_p1_y;
  logic [9:0]         w_p2_y;
  logic               w_frozen;
  logic               w_restart;
  logic signed [10:0] w_bx, w_by, w_nx, w_ny, w_d1, w_d2, w_a1, w_a2;
  logic signed [10:0] w_nx_c, w_ny_c;
  logic               w_hit_p1, w_hit_p2, w_miss_l, w_miss_r;
  logic               w_dir_x_n, w_dir_y_n;

  assign w_frozen  = (r_state == ST_OVER);
  assign w_restart = w_frozen && bus.serve;

  pong_paddle_ctrl u_paddle_p1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (bus.frame_tick),
    .i_hold    (w_frozen),
    .i_restart (w_restart),
    .i_up      (bus.p1_up),
    .i_down    (bus.p1_down),
    .o_y       (w_p1_y)
  );

  pong_paddle_ctrl u_paddle_p2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (bus.frame_tick),
    .i_hold    (w_frozen),
    .i_restart (w_restart),
    .i_up      (bus.p2_up),
    .i_down    (bus.p2_down),
    .o_y       (w_p2_y)
  );

  // Collisions look at the paddle registers as they were before this tick.
  always_comb begin
    w_bx = $signed({1'b0, r_ball_x});
    w_by = $signed({1'b0, r_ball_y});
    w_nx = r_dir_x ? (w_bx + C_BSTEP) : (w_bx - C_BSTEP);
    w_ny = r_dir_y ? (w_by + C_BSTEP) : (w_by - C_BSTEP);
    w_d1 = w_by - $signed({1'b0, w_p1_y});
    w_d2 = w_by - $signed({1'b0, w_p2_y});
    w_a1 = w_d1[10] ? -w_d1 : w_d1;
    w_a2 = w_d2[10] ? -w_d2 : w_d2;

    w_hit_p1 = !r_dir_x && ((w_nx - C_BHALF) <= C_P1_X) && (w_a1 <= C_REACH);
    w_hit_p2 = r_dir_x && ((w_nx + C_BHALF) >= C_P2_X) && (w_a2 <= C_REACH);
    w_miss_l = !r_dir_x && !w_hit_p1 && (w_nx <= C_BHALF);
    w_miss_r = r_dir_x && !w_hit_p2 && (w_nx >= C_X_HI);

    w_ny_c    = w_ny;
    w_dir_y_n = r_dir_y;
    if (w_ny <= C_BHALF) begin
      w_ny_c    = C_BHALF;
      w_dir_y_n = 1'b1;
    end else if (w_ny >= C_Y_HI) begin
      w_ny_c    = C_Y_HI;
      w_dir_y_n = 1'b0;
    end

    // A miss leaves dir_x alone, so the next serve heads toward the loser.
    w_nx_c    = w_nx;
    w_dir_x_n = r_dir_x;
    if (w_hit_p1) begin
      w_nx_c    = C_HIT1;
      w_dir_x_n = 1'b1;
    end else if (w_hit_p2) begin
      w_nx_c    = C_HIT2;
      w_dir_x_n = 1'b0;
    end else if (w_miss_l) begin
      w_nx_c    = C_BHALF;
    end else if (w_miss_r) begin
      w_nx_c    = C_X_HI;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SERVE;
      r_ball_x   <= C_CX;
      r_ball_y   <= C_CY;
      r_score_p1 <= 4'd0;
      r_score_p2 <= 4'd0;
      r_dir_x    <= 1'b1;
      r_dir_y    <= 1'b1;
      r_hold     <= 6'd0;
    end else if (bus.frame_tick) begin
      case (r_state)
        ST_SERVE: begin
          r_ball_x <= C_CX;
          r_ball_y <= C_CY;
          if (bus.serve) r_state <= ST_PLAY;
        end
        ST_PLAY: begin
          r_ball_x <= w_nx_c[10] ? 10'd0 : w_nx_c[9:0];
          r_ball_y <= w_ny_c[10] ? 10'd0 : w_ny_c[9:0];
          r_dir_x  <= w_dir_x_n;
          r_dir_y  <= w_dir_y_n;
          if (w_miss_l) begin
            r_score_p2 <= sat_inc(r_score_p2);
            r_state    <= ST_POINT;
          end else if (w_miss_r) begin
            r_score_p1 <= sat_inc(r_score_p1);
            r_state    <= ST_POINT;
          end
        end
        ST_POINT: begin
          if (r_hold == C_HOLD_LAST) begin
            r_hold <= 6'd0;
            if (r_score_p1 == 4'(SCORE_MAX) || r_score_p2 == 4'(SCORE_MAX)) begin
              r_state <= ST_OVER;
            end else begin
              r_state  <= ST_SERVE;
              r_ball_x <= C_CX;
              r_ball_y <= C_CY;
            end
          end else begin
            r_hold <= r_hold + 6'd1;
          end
        end
        ST_OVER: begin
          if (bus.serve) begin
            r_state    <= ST_SERVE;
            r_ball_x   <= C_CX;
            r_ball_y   <= C_CY;
            r_score_p1 <= 4'd0;
            r_score_p2 <= 4'd0;
            r_dir_x    <= 1'b1;
            r_dir_y    <= 1'b1;
            r_hold     <= 6'd0;
          end
        end
        default: r_state <= ST_SERVE;
      endcase
    end
  end

  assign bus.position_x_p1   = 10'(P1_X);
  assign bus.position_x_p2   = 10'(P2_X);
  assign bus.position_y_p1   = w_p1_y;
  assign bus.position_y_p2   = w_p2_y;
  assign bus.position_ball_x = r_ball_x;
  assign bus.position_ball_y = r_ball_y;
  assign bus.score_p1        = r_score_p1;
  assign bus.score_p2        = r_score_p2;
  assign bus.game_state      = r_state;
  assign bus.game_over       = (r_state == ST_OVER);
  assign bus.dbg_dir_x       = r_dir_x;
  assign bus.dbg_dir_y       = r_dir_y;

endmodule

// File: tb/tb_pong_position_engine.sv
// Bench for pong_position_engine: an integer reference model of the game feeds
// an expected queue per frame tick; the DUT outputs are checked after each tick.
module tb_pong_position_engine;

  localparam int W = 53;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [W-1:0] exp_q[$];

  int m_p1, m_p2, m_bx, m_by, m_s1, m_s2, m_st, m_hold;
  bit m_dx, m_dy;
  bit exp_serve_dir;

  pong_position_engine_if bus();

  pong_position_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs(input logic [W-1:0] e);
    check_eq("p1_x",    bus.position_x_p1, 10);
    check_eq("p2_x",    bus.position_x_p2, 629);
    check_eq("p1_y",    bus.position_y_p1, e[52:43]);
    check_eq("p2_y",    bus.position_y_p2, e[42:33]);
    check_eq("ball_x",  bus.position_ball_x, e[32:23]);
    check_eq("ball_y",  bus.position_ball_y, e[22:13]);
    check_eq("score1",  bus.score_p1, e[12:9]);
    check_eq("score2",  bus.score_p2, e[8:5]);
    check_eq("state",   bus.game_state, e[4:3]);
    check_eq("over",    bus.game_over, e[2]);
    check_eq("dir_x",   bus.dbg_dir_x, e[1]);
    check_eq("dir_y",   bus.dbg_dir_y, e[0]);
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_p1 = 240; m_p2 = 240; m_bx = 320; m_by = 240;
    m_s1 = 0; m_s2 = 0; m_st = 0; m_hold = 0;
    m_dx = 1'b1; m_dy = 1'b1;
  endtask

  function automatic int paddle_next(input int y, input bit up, input bit dn);
    int r;
    r = y;
    if (up && !dn) r = y - 4;
    else if (dn && !up) r = y + 4;
    if (r < 20) r = 20;
    if (r > 459) r = 459;
    return r;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [W-1:0] pack_model();
    return {10'(m_p1), 10'(m_p2), 10'(m_bx), 10'(m_by), 4'(m_s1), 4'(m_s2),
            2'(m_st), (m_st == 3), m_dx, m_dy};
  endfunction

  task automatic model_tick(input bit u1, input bit d1, input bit u2, input bit d2, input bit sv);
    int p1n, p2n, nx, ny, new_by;
    bit hit1, hit2;
    p1n = m_p1;
    p2n = m_p2;
    if (m_st != 3) begin
      p1n = paddle_next(m_p1, u1, d1);
      p2n = paddle_next(m_p2, u2, d2);
    end
    case (m_st)
      0: if (sv) m_st = 1;
      1: begin
        nx = m_bx + (m_dx ? 2 : -2);
        ny = m_by + (m_dy ? 2 : -2);
        if (ny <= 5) begin new_by = 5; m_dy = 1'b1; end
        else if (ny >= 474) begin new_by = 474; m_dy = 1'b0; end
        else new_by = ny;
        hit1 = !m_dx && (nx - 5 <= 10) && (iabs(m_by - m_p1) <= 25);
        hit2 = m_dx && (nx + 5 >= 629) && (iabs(m_by - m_p2) <= 25);
        if (hit1) begin m_bx = 16; m_dx = 1'b1; end
        else if (hit2) begin m_bx = 623; m_dx = 1'b0; end
        else if (!m_dx && nx <= 5) begin
          m_bx = 5; m_st = 2; exp_serve_dir = 1'b0;
          if (m_s2 < 9) m_s2++;
        end else if (m_dx && nx >= 634) begin
          m_bx = 634; m_st = 2; exp_serve_dir = 1'b1;
          if (m_s1 < 9) m_s1++;
        end else m_bx = nx;
        m_by = new_by;
      end
      2: begin
        if (m_hold == 59) begin
          m_hold = 0;
          if (m_s1 == 9 || m_s2 == 9) m_st = 3;
          else begin m_st = 0; m_bx = 320; m_by = 240; end
        end else m_hold++;
      end
      default: if (sv) begin model_reset(); p1n = 240; p2n = 240; end
    endcase
    m_p1 = p1n;
    m_p2 = p2n;
  endtask

  function automatic bit [1:0] ai(input int pad, input int tgt);
    if (pad > tgt + 3) return 2'b10;
    if (pad < tgt - 3) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- driver ----------------
  task automatic do_tick(input bit u1, input bit d1, input bit u2, input bit d2, input bit sv);
    logic [W-1:0] e;
    @(negedge clk);
    bus.p1_up = u1; bus.p1_down = d1; bus.p2_up = u2; bus.p2_down = d2;
    bus.serve = sv; bus.frame_tick = 1'b1;
    model_tick(u1, d1, u2, d2, sv);
    exp_q.push_back(pack_model());
    @(negedge clk);
    bus.frame_tick = 1'b0;
    e = exp_q.pop_front();
    compare_outputs(e);
    @(negedge clk);
    compare_outputs(e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_serve_dir = 1'b1;
    bus.frame_tick = 1'b0;
    bus.p1_up = 1'b0; bus.p1_down = 1'b0;
    bus.p2_up = 1'b0; bus.p2_down = 1'b0;
    bus.serve = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_outputs(pack_model());
    rst_n = 1'b1;

    repeat (5) do_tick(0, 0, 0, 0, 0);
    repeat (100) do_tick(1, 0, 0, 0, 0);
    check_eq("p1_clamp_top", bus.position_y_p1, 20);
    repeat (5) do_tick(1, 1, 0, 0, 0);
    check_eq("p1_both_hold", bus.position_y_p1, 20);
    repeat (60) do_tick(0, 0, 0, 1, 0);
    check_eq("p2_clamp_bot", bus.position_y_p2, 459);
    repeat (55) do_tick(0, 1, 1, 0, 0);

    // Rally: both paddles track the ball.
    do_tick(0, 0, 0, 0, 1);
    check_eq("serve_to_play", bus.game_state, 1);
    for (int t = 0; t < 400; t++) begin
      bit [1:0] a1;
      bit [1:0] a2;
      bit pre_top;
      a1 = ai(m_p1, m_by);
      a2 = ai(m_p2, m_by);
      pre_top = (m_st == 1) && (m_by == 6) && !m_dy;
      do_tick(a1[1], a1[0], a2[1], a2[0], m_st == 0);
      if (t == 151) begin
        check_eq("p2_hit_x", bus.position_ball_x, 623);
        check_eq("p2_hit_dir", bus.dbg_dir_x, 0);
        check_eq("p2_hit_score", bus.score_p1, 0);
      end
      if (pre_top) begin
        check_eq("top_wall_y", bus.position_ball_y, 5);
        check_eq("top_wall_dir", bus.dbg_dir_y, 1);
      end
    end

    // p2 parks at the top so p1 racks up points until the game ends.
    for (int t = 0; t < 6000 && m_st != 3; t++) begin
      bit [1:0] a1;
      int prev_st;
      a1 = ai(m_p1, m_by);
      prev_st = m_st;
      do_tick(a1[1], a1[0], 1'b1, 1'b0, m_st == 0);
      if (prev_st == 2 && m_st == 0) begin
        check_eq("reserve_x", bus.position_ball_x, 320);
        check_eq("reserve_y", bus.position_ball_y, 240);
        check_eq("reserve_dir", bus.dbg_dir_x, 32'(exp_serve_dir));
      end
    end
    check_eq("game_over", bus.game_over, 1);
    check_eq("final_score_p1", bus.score_p1, 9);

    repeat (5) do_tick(1, 0, 0, 1, 0);
    do_tick(0, 0, 0, 0, 1);
    check_eq("restart_state", bus.game_state, 0);
    check_eq("restart_score", bus.score_p1, 0);

    // Asynchronous reset mid-play, away from any clock edge.
    do_tick(0, 0, 0, 0, 1);
    repeat (20) do_tick(0, 1, 0, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs(pack_model());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) do_tick(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
